// File: rtl/fill_pkg.sv
// Shared types and screen defaults for the rectangle fill engine and its task wrappers.
package fill_pkg;

    localparam int unsigned SCREEN_W_DEFAULT = 160;
    localparam int unsigned SCREEN_H_DEFAULT = 120;

    typedef enum logic [1:0] {
        SOLID,
        COL_STRIPE,
        ROW_STRIPE,
        CHECKER
    } fill_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        FILL,
        DONE
    } fill_state_t;

endpackage

// File: rtl/rect_raster_ctr.sv
// Column-major raster counter over [x0, xe) x [y0, ye); y advances first.
module rect_raster_ctr #(
    parameter int unsigned XW = 8,
    parameter int unsigned YW = 7
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          load_i,
    input  logic [XW-1:0] x0_i,
    input  logic [YW-1:0] y0_i,
    input  logic [XW:0]   xe_i,
    input  logic [YW:0]   ye_i,
    input  logic          en_i,
    output logic [XW-1:0] cx_o,
    output logic [YW-1:0] cy_o,
    output logic          last_o
);

    localparam logic [XW:0] XOne = (XW+1)'(1);
    localparam logic [YW:0] YOne = (YW+1)'(1);

    logic [XW-1:0] cx_q;
    logic [YW-1:0] cy_q, y0_q;
    logic [XW:0]   xe_q;
    logic [YW:0]   ye_q;
    logic          col_end, row_end;

    // Exclusive bounds are one bit wider, so compare cx+1 / cy+1 in the wide domain.
    assign col_end = (({1'b0, cy_q} + YOne) == ye_q);
    assign row_end = (({1'b0, cx_q} + XOne) == xe_q);
    assign last_o  = col_end && row_end;
    assign cx_o    = cx_q;
    assign cy_o    = cy_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cx_q <= '0;
            cy_q <= '0;
            y0_q <= '0;
            xe_q <= '0;
            ye_q <= '0;
        end else if (load_i) begin
            cx_q <= x0_i;
            cy_q <= y0_i;
            y0_q <= y0_i;
            xe_q <= xe_i;
            ye_q <= ye_i;
        end else if (en_i) begin
            if (col_end) begin
                cy_q <= y0_q;
                cx_q <= cx_q + XW'(1);
            end else begin
                cy_q <= cy_q + YW'(1);
            end
        end
    end

endmodule

// File: rtl/rect_fill.sv
// Clipped rectangle fill onto the VGA adapter plot interface, one pixel per clock.
module rect_fill
    import fill_pkg::*;
#(
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 7,
    parameter int unsigned CW       = 3,
    parameter int unsigned SCREEN_W = SCREEN_W_DEFAULT,
    parameter int unsigned SCREEN_H = SCREEN_H_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] colour,
    input  logic [XW-1:0] x0,
    input  logic [YW-1:0] y0,
    input  logic [XW-1:0] w,
    input  logic [YW-1:0] h,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    localparam logic [XW:0] ScrW = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] ScrH = (YW+1)'(SCREEN_H);

    fill_state_t   state_q, state_d;
    fill_mode_t    mode_q;
    logic [CW-1:0] colour_q;
    logic [XW-1:0] x0_q, w_q;
    logic [YW-1:0] y0_q, h_q;

    logic          done_q, done_d, plot_q, plot_d;
    logic [XW-1:0] vx_q, vx_d;
    logic [YW-1:0] vy_q, vy_d;
    logic [CW-1:0] vc_q, vc_d, pix_colour;

    logic [XW:0]   xsum, xe;
    logic [YW:0]   ysum, ye;
    logic          empty, ctr_load, ctr_en, last;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;

    assign xsum  = {1'b0, x0_q} + {1'b0, w_q};
    assign ysum  = {1'b0, y0_q} + {1'b0, h_q};
    assign xe    = (xsum > ScrW) ? ScrW : xsum;
    assign ye    = (ysum > ScrH) ? ScrH : ysum;
    assign empty = (w_q == '0) || (h_q == '0) ||
                   ({1'b0, x0_q} >= ScrW) || ({1'b0, y0_q} >= ScrH);

    rect_raster_ctr #(
        .XW (XW),
        .YW (YW)
    ) u_ctr (
        .clk_i  (clk),
        .rst_i  (rst),
        .load_i (ctr_load),
        .x0_i   (x0_q),
        .y0_i   (y0_q),
        .xe_i   (xe),
        .ye_i   (ye),
        .en_i   (ctr_en),
        .cx_o   (cx),
        .cy_o   (cy),
        .last_o (last)
    );

    always_comb begin
        pix_colour = colour_q;
        unique case (mode_q)
            SOLID:      pix_colour = colour_q;
            COL_STRIPE: pix_colour = cx[CW-1:0];
            ROW_STRIPE: pix_colour = cy[CW-1:0];
            CHECKER:    pix_colour = (cx[0] ^ cy[0]) ? '0 : colour_q;
            default:    pix_colour = colour_q;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        ctr_load = 1'b0;
        ctr_en   = 1'b0;
        plot_d   = 1'b0;
        done_d   = 1'b0;
        vx_d     = vx_q;
        vy_d     = vy_q;
        vc_d     = vc_q;
        unique case (state_q)
            IDLE: begin
                if (start) state_d = SETUP;
            end
            SETUP: begin
                if (empty) begin
                    state_d = DONE;
                end else begin
                    ctr_load = 1'b1;
                    state_d  = FILL;
                end
            end
            FILL: begin
                plot_d = 1'b1;
                vx_d   = cx;
                vy_d   = cy;
                vc_d   = pix_colour;
                ctr_en = 1'b1;
                if (last) state_d = DONE;
            end
            DONE: begin
                done_d = 1'b1;
                if (!start) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mode_q   <= SOLID;
            colour_q <= '0;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            done_q   <= 1'b0;
            plot_q   <= 1'b0;
            vx_q     <= '0;
            vy_q     <= '0;
            vc_q     <= '0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            vc_q    <= vc_d;
            if (state_q == IDLE && start) begin
                mode_q   <= fill_mode_t'(mode);
                colour_q <= colour;
                x0_q     <= x0;
                y0_q     <= y0;
                w_q      <= w;
                h_q      <= h;
            end
        end
    end

    assign done       = done_q;
    assign vga_plot   = plot_q;
    assign vga_x      = vx_q;
    assign vga_y      = vy_q;
    assign vga_colour = vc_q;

endmodule

// File: tb/tb_rect_fill.sv
// Directed bench for rect_fill: table of whole-fill vectors plus handshake and reset sequences.
module tb_rect_fill;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] colour = 3'd0;
    logic [7:0] x0 = 8'd0;
    logic [6:0] y0 = 7'd0;
    logic [7:0] w = 8'd0;
    logic [6:0] h = 7'd0;
    logic       done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    always #5 clk = ~clk;

    rect_fill dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .mode       (mode),
        .colour     (colour),
        .x0         (x0),
        .y0         (y0),
        .w          (w),
        .h          (h),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    typedef struct {
        int x0, y0, w, h, mode, col;
        int plots, done_cyc;
        int fx, fy, fc, lx, ly, lc;
    } vec_t;

    vec_t vecs[8];
    int   checks = 0;
    int   errors = 0;

    // Results of the most recent run_fill.
    int nplot, done_cyc, first_cyc, fx, fy, fc, lx, ly, lc, nout, nbadsolid;
    int px[64], py[64], pc[64];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d", name, act, exp);
        end
    endtask

    task automatic run_fill(input int ax0, input int ay0, input int aw, input int ah,
                            input int amode, input int acol, input bit hold);
        int cyc;
        @(negedge clk);
        x0 = 8'(ax0); y0 = 7'(ay0); w = 8'(aw); h = 7'(ah);
        mode = 2'(amode); colour = 3'(acol);
        start = 1'b1;
        @(posedge clk);
        cyc = 0; nplot = 0; done_cyc = -1; first_cyc = -1; nout = 0; nbadsolid = 0;
        fx = -1; fy = -1; fc = -1; lx = -1; ly = -1; lc = -1;
        while (cyc < 30000 && done_cyc < 0) begin
            @(negedge clk);
            if (!hold) begin
                start = 1'b0;
                x0 = 8'd77; y0 = 7'd33; w = 8'd5; h = 7'd5; mode = 2'd1; colour = 3'd2;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (vga_plot) begin
                if (nplot == 0) begin
                    first_cyc = cyc;
                    fx = int'(vga_x); fy = int'(vga_y); fc = int'(vga_colour);
                end
                if (nplot < 64) begin
                    px[nplot] = int'(vga_x); py[nplot] = int'(vga_y);
                    pc[nplot] = int'(vga_colour);
                end
                lx = int'(vga_x); ly = int'(vga_y); lc = int'(vga_colour);
                if (vga_x >= 8'd160 || vga_y >= 7'd120) nout++;
                if (int'(vga_colour) != acol) nbadsolid++;
                nplot++;
            end
            if (done) done_cyc = cyc;
        end
        if (done_cyc < 0) chk("done_timeout", 0, 1);
        if (!hold) repeat (3) @(posedge clk);
    endtask

    initial begin
        //            x0   y0   w    h  mode col plots  done   fx   fy fc  lx   ly  lc
        vecs[0] = '{  0,   0, 160, 120, 0,  5, 19200, 19202,   0,   0, 5, 159, 119, 5};
        vecs[1] = '{ 10,  20,   4,   3, 1,  6,    12,    14,  10,  20, 2,  13,  22, 5};
        vecs[2] = '{ 10,  20,   4,   3, 2,  6,    12,    14,  10,  20, 4,  13,  22, 6};
        vecs[3] = '{150, 115,  20,  20, 3,  7,    50,    52, 150, 115, 0, 159, 119, 7};
        vecs[4] = '{ 30,  30,   0,   5, 0,  3,     0,     2,  -1,  -1,-1,  -1,  -1,-1};
        vecs[5] = '{200,  10,  10,  10, 0,  3,     0,     2,  -1,  -1,-1,  -1,  -1,-1};
        vecs[6] = '{ 10, 120,   5,   5, 0,  3,     0,     2,  -1,  -1,-1,  -1,  -1,-1};
        vecs[7] = '{159, 119,   1,   1, 3,  4,     1,     3, 159, 119, 4, 159, 119, 4};

        // Reset state, held across several edges.
        repeat (3) @(posedge clk);
        #1;
        chk("rst_plot", int'(vga_plot), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_xyc", int'({vga_x, vga_y, vga_colour}), 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            run_fill(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h,
                     vecs[i].mode, vecs[i].col, 1'b0);
            chk($sformatf("v%0d_plots", i), nplot, vecs[i].plots);
            chk($sformatf("v%0d_done_cyc", i), done_cyc, vecs[i].done_cyc);
            chk($sformatf("v%0d_offscreen", i), nout, 0);
            if (vecs[i].plots > 0) begin
                chk($sformatf("v%0d_first_cyc", i), first_cyc, 2);
                chk($sformatf("v%0d_first_xyc", i), fx * 10000 + fy * 10 + fc,
                    vecs[i].fx * 10000 + vecs[i].fy * 10 + vecs[i].fc);
                chk($sformatf("v%0d_last_xyc", i), lx * 10000 + ly * 10 + lc,
                    vecs[i].lx * 10000 + vecs[i].ly * 10 + vecs[i].lc);
            end
            if (vecs[i].mode == 0 && vecs[i].plots > 0)
                chk($sformatf("v%0d_solid_colour", i), nbadsolid, 0);
            if (i == 3) begin
                // (150,116): even x, even y -> base colour.
                chk("chk_150_116_xy", px[1] * 1000 + py[1], 150116);
                chk("chk_150_116_col", pc[1], 7);
            end
        end

        // Pixel-by-pixel order and colours for the stripe modes.
        begin
            int col_exp[12] = '{2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5};
            int row_exp[3]  = '{4, 5, 6};
            run_fill(10, 20, 4, 3, 1, 0, 1'b0);
            for (int k = 0; k < 12; k++) begin
                chk($sformatf("col_xy%0d", k), px[k] * 1000 + py[k],
                    (10 + k / 3) * 1000 + 20 + k % 3);
                chk($sformatf("col_c%0d", k), pc[k], col_exp[k]);
            end
            run_fill(10, 20, 4, 3, 2, 0, 1'b0);
            for (int k = 0; k < 12; k++)
                chk($sformatf("row_c%0d", k), pc[k], row_exp[k % 3]);
        end

        // Handshake: start held through DONE must not retrigger.
        run_fill(0, 0, 2, 2, 0, 1, 1'b1);
        chk("hs_plots", nplot, 4);
        chk("hs_done_cyc", done_cyc, 6);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            chk($sformatf("hs_hold_done%0d", k), int'(done), 1);
            chk($sformatf("hs_hold_plot%0d", k), int'(vga_plot), 0);
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("hs_done_clear", int'(done), 0);
        run_fill(5, 5, 2, 3, 0, 2, 1'b0);
        chk("hs_refill_plots", nplot, 6);

        // Reset in the middle of a full-screen fill.
        begin
            int cnt = 0;
            int guard = 0;
            @(negedge clk);
            x0 = 8'd0; y0 = 7'd0; w = 8'd160; h = 7'd120; mode = 2'd0; colour = 3'd5;
            start = 1'b1;
            @(posedge clk);
            @(negedge clk);
            start = 1'b0;
            while (cnt < 130 && guard < 1000) begin
                @(posedge clk);
                #1;
                guard++;
                if (vga_plot) cnt++;
            end
            chk("mid_plot_count", cnt, 130);
            chk("mid_last_y", int'(vga_y), 9);
            #2;
            rst = 1'b1;
            #1;
            chk("mid_rst_plot", int'(vga_plot), 0);
            chk("mid_rst_y", int'(vga_y), 0);
            chk("mid_rst_colour", int'(vga_colour), 0);
            cnt = 0;
            repeat (4) begin
                @(posedge clk);
                #1;
                if (vga_plot) cnt++;
            end
            chk("mid_rst_noplot", cnt, 0);
            @(negedge clk);
            rst = 1'b0;
            repeat (10) begin
                @(posedge clk);
                #1;
                if (vga_plot || done) cnt++;
            end
            chk("mid_idle_after", cnt, 0);
            run_fill(3, 4, 2, 2, 0, 6, 1'b0);
            chk("mid_refill_plots", nplot, 4);
            chk("mid_refill_first", fx * 10000 + fy * 10 + fc, 3 * 10000 + 4 * 10 + 6);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
